// File: rtl/fixed_pkg.sv
// Fixed-point types shared by the divider requester slice: Q(32-F).F operands
// and the 48-bit wide dividend/quotient seen on the Divider side.
package fixed_pkg;

  localparam int unsigned FRAC_BITS_DEFAULT = 16;

  typedef logic signed [31:0] fixed_t;
  typedef logic signed [47:0] wide_t;

  localparam fixed_t FIXED_MAX = 32'sh7FFF_FFFF;
  localparam fixed_t FIXED_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    OUT
  } req_state_t;

  // Pre-scales the dividend so the integer quotient comes back in Q format.
  function automatic wide_t to_dividend(fixed_t a, int unsigned frac_bits);
    return wide_t'(a) <<< frac_bits;
  endfunction

endpackage

// File: rtl/div_requester_if.sv
// Request/result handshake plus the three AXI-Stream channels to the Divider.
// master: the requester side; slave: the environment (client + Divider).
interface div_requester_if;
  import fixed_pkg::*;

  logic   in_valid;
  logic   in_ready;
  fixed_t in_a;
  fixed_t in_b;

  logic   out_valid;
  logic   out_ready;
  fixed_t out_q;
  logic   out_div_by_zero;

  logic   m_axis_dividend_tvalid;
  logic   m_axis_dividend_tready;
  wide_t  m_axis_dividend_tdata;

  logic   m_axis_divisor_tvalid;
  logic   m_axis_divisor_tready;
  fixed_t m_axis_divisor_tdata;

  logic   s_axis_dout_tvalid;
  logic   s_axis_dout_tready;
  wide_t  s_axis_dout_tdata;

  modport master (
    input  in_valid, in_a, in_b, out_ready,
    input  m_axis_dividend_tready, m_axis_divisor_tready,
    input  s_axis_dout_tvalid, s_axis_dout_tdata,
    output in_ready, out_valid, out_q, out_div_by_zero,
    output m_axis_dividend_tvalid, m_axis_dividend_tdata,
    output m_axis_divisor_tvalid, m_axis_divisor_tdata,
    output s_axis_dout_tready
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready,
    output m_axis_dividend_tready, m_axis_divisor_tready,
    output s_axis_dout_tvalid, s_axis_dout_tdata,
    input  in_ready, out_valid, out_q, out_div_by_zero,
    input  m_axis_dividend_tvalid, m_axis_dividend_tdata,
    input  m_axis_divisor_tvalid, m_axis_divisor_tdata,
    input  s_axis_dout_tready
  );

endinterface

// File: rtl/fixed_saturate.sv
// Clamps a signed 48-bit quotient into the signed 32-bit fixed-point range.
module fixed_saturate
  import fixed_pkg::*;
(
  input  wide_t  din,
  output fixed_t dout
);

  localparam wide_t WIDE_MAX = wide_t'(FIXED_MAX);
  localparam wide_t WIDE_MIN = wide_t'(FIXED_MIN);

  always_comb begin
    if (din > WIDE_MAX) begin
      dout = FIXED_MAX;
    end else if (din < WIDE_MIN) begin
      dout = FIXED_MIN;
    end else begin
      dout = din[31:0];
    end
  end

endmodule

// File: rtl/div_requester.sv
// Single-outstanding fixed-point divide requester in front of an AXI-Stream Divider.
// Define DIV_ZERO_CHECK_EN to short-circuit b==0 with a saturated result and flag.
module div_requester
  import fixed_pkg::*;
#(
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEFAULT,
  parameter int unsigned MAX_WAIT  = 64
) (
  input  logic clk,
  input  logic reset,
  div_requester_if.master bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  req_state_t        state;
  req_state_t        state_nxt;
  fixed_t            a_q;
  fixed_t            b_q;
  fixed_t            q_q;
  fixed_t            sat_q;
  logic              dvd_done;
  logic              dvs_done;
  logic [WAIT_W-1:0] wait_cnt;
  logic              zero_div;
  logic              hs_in;
  logic              hs_dvd;
  logic              hs_dvs;
  logic              hs_dout;

  fixed_saturate u_sat (
    .din  (bus.s_axis_dout_tdata),
    .dout (sat_q)
  );

`ifdef DIV_ZERO_CHECK_EN
  logic dbz_q;
  assign zero_div            = (bus.in_b == '0);
  assign bus.out_div_by_zero = dbz_q;
`else
  assign zero_div            = 1'b0;
  assign bus.out_div_by_zero = 1'b0;
`endif

  assign hs_in   = bus.in_valid & bus.in_ready;
  assign hs_dvd  = bus.m_axis_dividend_tvalid & bus.m_axis_dividend_tready;
  assign hs_dvs  = bus.m_axis_divisor_tvalid & bus.m_axis_divisor_tready;
  assign hs_dout = bus.s_axis_dout_tvalid & bus.s_axis_dout_tready;

  assign bus.m_axis_dividend_tdata = to_dividend(a_q, FRAC_BITS);
  assign bus.m_axis_divisor_tdata  = b_q;
  assign bus.out_q                 = q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // SEND leaves once both channels are done, counting a handshake happening this cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_nxt = zero_div ? OUT : SEND;
      SEND: if ((dvd_done || hs_dvd) && (dvs_done || hs_dvs)) state_nxt = WAIT;
      WAIT: if (bus.s_axis_dout_tvalid) state_nxt = OUT;
      OUT:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready               = 1'b0;
    bus.m_axis_dividend_tvalid = 1'b0;
    bus.m_axis_divisor_tvalid  = 1'b0;
    bus.s_axis_dout_tready     = 1'b0;
    bus.out_valid              = 1'b0;
    unique case (state)
      IDLE: bus.in_ready = 1'b1;
      SEND: begin
        bus.m_axis_dividend_tvalid = ~dvd_done;
        bus.m_axis_divisor_tvalid  = ~dvs_done;
      end
      WAIT: bus.s_axis_dout_tready = 1'b1;
      OUT:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      dvd_done <= 1'b0;
      dvs_done <= 1'b0;
      wait_cnt <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dbz_q    <= 1'b0;
`endif
    end else begin
      if (hs_in) begin
        a_q      <= bus.in_a;
        b_q      <= bus.in_b;
        dvd_done <= 1'b0;
        dvs_done <= 1'b0;
        if (zero_div) q_q <= bus.in_a[31] ? FIXED_MIN : FIXED_MAX;
`ifdef DIV_ZERO_CHECK_EN
        dbz_q    <= zero_div;
`endif
      end
      if (hs_dvd) dvd_done <= 1'b1;
      if (hs_dvs) dvs_done <= 1'b1;
      if (hs_dout) q_q <= sat_q;
      if (state == WAIT) begin
        if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // The Divider is expected to answer within MAX_WAIT cycles of entering WAIT.
  a_wait_bound: assert property (@(posedge clk) disable iff (reset)
    (state == WAIT) |-> (wait_cnt < WAIT_W'(MAX_WAIT)));

endmodule

// File: tb/tb_div_requester.sv
// Randomized bench for div_requester: transaction-level reference model, a
// stimulus-side Divider model, and a per-cycle compare of every output.
`timescale 1ns/1ps
module tb_div_requester;
  import fixed_pkg::*;

  localparam int unsigned FB = 16;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  typedef struct {
    fixed_t a;
    fixed_t b;
  } req_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div_requester_if bus ();

  div_requester #(
    .FRAC_BITS (FB),
    .MAX_WAIT  (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // stimulus knobs (written by the test thread at posedges)
  req_t        req_q[$];
  bit          dir_mode   = 1'b1;
  bit          hold_mode  = 1'b0;
  int unsigned dir_lat    = 0;
  int unsigned rst_cycles = 3;
  int unsigned hold_cnt   = 0;

  // transaction reference state (what must be true after the coming edge)
  bit     inflight, dz_req, dvd_taken, dvs_taken, res_taken;
  fixed_t cur_a, cur_b, exp_q;
  bit     exp_dz;

  // Divider model
  bit          dv_pending;
  int unsigned dv_cnt;
  wide_t       dv_dvd, dv_res;
  fixed_t      dv_dvs;

  // observations
  int unsigned completed = 0, cyc = 0, in_cyc = 0, ov_cyc = 0;
  int unsigned dvd_vcyc = 0, dvs_vcyc = 0;
  bit          ov_seen;
  fixed_t      last_q;
  bit          last_dz;
  wide_t       last_dvd;

  function automatic wide_t ref_dividend(fixed_t a);
    longint v;
    v = longint'(a) * (longint'(1) << FB);
    return wide_t'(v);
  endfunction

  function automatic fixed_t ref_q(fixed_t a, fixed_t b);
    longint q;
    if (b == 0) return DZ_EN ? ((a < 0) ? FIXED_MIN : FIXED_MAX) : '0;
    q = (longint'(a) * (longint'(1) << FB)) / longint'(b);
    if (q > 64'sd2147483647) return FIXED_MAX;
    if (q < -64'sd2147483648) return FIXED_MIN;
    return fixed_t'(q);
  endfunction

  function automatic wide_t divider_result(wide_t n, fixed_t d);
    longint q;
    if (d == 0) return '0;
    q = longint'(n) / longint'(d);
    return wide_t'(q);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: outputs are checked 1ns after every rising edge.
  initial begin
    bit e_dvd_v, e_dvs_v, e_dout_r, e_out_v;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_q", bus.out_q, '0);
        check("rst_out_dz", bus.out_div_by_zero, 1'b0);
        check("rst_dvd_tvalid", bus.m_axis_dividend_tvalid, 1'b0);
        check("rst_dvs_tvalid", bus.m_axis_divisor_tvalid, 1'b0);
        check("rst_dout_tready", bus.s_axis_dout_tready, 1'b0);
        check("rst_dvd_tdata", bus.m_axis_dividend_tdata, '0);
        check("rst_dvs_tdata", bus.m_axis_divisor_tdata, '0);
      end else begin
        e_dvd_v  = inflight && !dz_req && !dvd_taken;
        e_dvs_v  = inflight && !dz_req && !dvs_taken;
        e_dout_r = inflight && !dz_req && dvd_taken && dvs_taken && !res_taken;
        e_out_v  = inflight && (dz_req || res_taken);
        check("in_ready", bus.in_ready, !inflight);
        check("dvd_tvalid", bus.m_axis_dividend_tvalid, e_dvd_v);
        check("dvs_tvalid", bus.m_axis_divisor_tvalid, e_dvs_v);
        check("dout_tready", bus.s_axis_dout_tready, e_dout_r);
        check("out_valid", bus.out_valid, e_out_v);
        if (e_dvd_v) check("dvd_tdata", bus.m_axis_dividend_tdata, ref_dividend(cur_a));
        if (e_dvs_v) check("dvs_tdata", bus.m_axis_divisor_tdata, cur_b);
        if (e_out_v) begin
          check("out_q", bus.out_q, exp_q);
          check("out_dz", bus.out_div_by_zero, exp_dz);
        end
        if (bus.m_axis_dividend_tvalid) dvd_vcyc++;
        if (bus.m_axis_divisor_tvalid) dvs_vcyc++;
        if (bus.out_valid && !ov_seen) begin
          ov_seen = 1'b1;
          ov_cyc  = cyc;
        end
      end
    end
  end

  // Driver + model update: drive at the falling edge, then record which
  // handshakes the next rising edge will take.
  initial begin
    bit   hs_in, hs_dvd, hs_dvs, hs_dout, hs_out;
    req_t r;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    bus.m_axis_dividend_tready = 1'b0;
    bus.m_axis_divisor_tready = 1'b0;
    bus.s_axis_dout_tvalid = 1'b0;
    bus.s_axis_dout_tdata = '0;
    forever begin
      @(negedge clk);
      if (rst_cycles > 0) begin
        reset = 1'b1;
        rst_cycles--;
      end else begin
        reset = 1'b0;
      end
      if (reset) begin
        inflight = 0; dz_req = 0; dvd_taken = 0; dvs_taken = 0; res_taken = 0;
        dv_pending = 0; hold_cnt = 0;
        bus.in_valid = 1'b0;
        bus.s_axis_dout_tvalid = 1'b0;
      end else begin
        bus.in_valid = (req_q.size() > 0) && (dir_mode || ($urandom_range(0, 2) != 0));
        if (req_q.size() > 0) begin
          bus.in_a = req_q[0].a;
          bus.in_b = req_q[0].b;
        end else begin
          bus.in_a = $urandom;
          bus.in_b = $urandom;
        end
        bus.m_axis_dividend_tready = dir_mode ? 1'b1 : 1'($urandom_range(0, 1));
        if (hold_mode) bus.m_axis_divisor_tready = dvd_taken && (hold_cnt == 0);
        else bus.m_axis_divisor_tready = dir_mode ? 1'b1 : 1'($urandom_range(0, 1));
        bus.out_ready = dir_mode ? 1'b1 : 1'($urandom_range(0, 1));
        if (dv_pending && dv_cnt == 0) begin
          bus.s_axis_dout_tvalid = 1'b1;
          bus.s_axis_dout_tdata  = dv_res;
        end else if (!dv_pending && !dir_mode && $urandom_range(0, 3) == 0) begin
          bus.s_axis_dout_tvalid = 1'b1;
          bus.s_axis_dout_tdata  = wide_t'({$urandom(), $urandom()});
        end else begin
          bus.s_axis_dout_tvalid = 1'b0;
        end

        hs_in   = bus.in_valid && bus.in_ready;
        hs_dvd  = bus.m_axis_dividend_tvalid && bus.m_axis_dividend_tready;
        hs_dvs  = bus.m_axis_divisor_tvalid && bus.m_axis_divisor_tready;
        hs_dout = bus.s_axis_dout_tvalid && bus.s_axis_dout_tready;
        hs_out  = bus.out_valid && bus.out_ready;

        if (hs_out) begin
          inflight = 1'b0;
          completed++;
          last_q  = bus.out_q;
          last_dz = bus.out_div_by_zero;
        end
        if (hs_in) begin
          r = req_q.pop_front();
          cur_a = r.a;
          cur_b = r.b;
          inflight = 1'b1;
          dz_req = DZ_EN && (r.b == 0);
          dvd_taken = 0; dvs_taken = 0; res_taken = 0;
          exp_q = ref_q(r.a, r.b);
          exp_dz = dz_req;
          in_cyc = cyc; ov_seen = 0; dvd_vcyc = 0; dvs_vcyc = 0; hold_cnt = 0;
        end
        if (hold_cnt > 0) hold_cnt--;
        if (hs_dvd) begin
          dvd_taken = 1'b1;
          dv_dvd = bus.m_axis_dividend_tdata;
          last_dvd = bus.m_axis_dividend_tdata;
          if (hold_mode) hold_cnt = 3;
        end
        if (hs_dvs) begin
          dvs_taken = 1'b1;
          dv_dvs = bus.m_axis_divisor_tdata;
        end
        if (dv_pending && dv_cnt > 0) dv_cnt--;
        if (hs_dout) begin
          res_taken = 1'b1;
          dv_pending = 1'b0;
        end else if (!dv_pending && !res_taken && inflight && dvd_taken && dvs_taken) begin
          dv_pending = 1'b1;
          dv_cnt = dir_mode ? dir_lat : $urandom_range(0, 6);
          dv_res = divider_result(dv_dvd, dv_dvs);
        end
      end
    end
  end

  task automatic wait_done(input int unsigned target, input int unsigned bound, input string name);
    int unsigned n = 0;
    while (completed < target && n < bound) begin
      @(posedge clk);
      n++;
    end
    check({name, "_done"}, completed >= target, 1'b1);
  endtask

  task automatic run_directed(input string name, input fixed_t a, input fixed_t b,
                              input int unsigned lat, input fixed_t q_exp, input bit dz_exp,
                              input int exp_latency);
    req_t r;
    int unsigned target;
    dir_mode = 1'b1;
    dir_lat  = lat;
    target   = completed + 1;
    r.a = a;
    r.b = b;
    req_q.push_back(r);
    wait_done(target, 200, name);
    check({name, "_q"}, last_q, q_exp);
    check({name, "_dz"}, last_dz, dz_exp);
    if (exp_latency >= 0) check({name, "_latency"}, ov_cyc - in_cyc, exp_latency);
  endtask

  initial begin
    req_t        r;
    int unsigned n, target;
    repeat (6) @(posedge clk);

    run_directed("div10by2", 32'h000A_0000, 32'h0002_0000, 0, 32'h0005_0000, 1'b0, 3);
    check("div10by2_dividend", last_dvd, 48'h000A_0000_0000);
    run_directed("neg1p5", 32'hFFFD_0000, 32'h0002_0000, 2, 32'hFFFE_8000, 1'b0, 5);
    run_directed("sat_pos", 32'h7FFF_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 1'b0, 4);
    run_directed("sat_neg", 32'h8000_0000, 32'h0000_0001, 0, 32'h8000_0000, 1'b0, 3);
`ifdef DIV_ZERO_CHECK_EN
    run_directed("dz_pos", 32'h0001_0000, 32'h0000_0000, 0, 32'h7FFF_FFFF, 1'b1, 1);
    check("dz_pos_no_tvalid", dvd_vcyc + dvs_vcyc, 0);
    run_directed("dz_neg", 32'hFFFF_0000, 32'h0000_0000, 0, 32'h8000_0000, 1'b1, 1);
    check("dz_neg_no_tvalid", dvd_vcyc + dvs_vcyc, 0);
`else
    run_directed("b_zero", 32'h0001_0000, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 3);
    check("b_zero_sent", dvd_vcyc + dvs_vcyc, 2);
`endif

    // divisor ready held low 3 cycles after the dividend handshake
    hold_mode = 1'b1;
    run_directed("hold", 32'h0003_0000, 32'h0001_0000, 1, 32'h0003_0000, 1'b0, 8);
    check("hold_dvd_cycles", dvd_vcyc, 1);
    check("hold_dvs_cycles", dvs_vcyc, 5);
    @(posedge clk);
    hold_mode = 1'b0;

    // reset while waiting on a slow Divider
    dir_mode = 1'b1;
    dir_lat  = 20;
    r.a = 32'h0001_0000;
    r.b = 32'h0001_0000;
    req_q.push_back(r);
    n = 0;
    while (!(inflight && dvd_taken && dvs_taken) && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_in_wait", bus.s_axis_dout_tready, 1'b1);
    target = completed;
    rst_cycles = 3;
    repeat (6) @(posedge clk);
    check("reset_dropped_result", completed, target);
    run_directed("after_reset", 32'h0006_0000, 32'h0003_0000, 0, 32'h0002_0000, 1'b0, 3);

    // randomized traffic
    @(posedge clk);
    dir_mode = 1'b0;
    target = completed + 80;
    for (int unsigned i = 0; i < 80; i++) begin
      r.a = $urandom;
      case ($urandom_range(0, 9))
        0: r.b = '0;
        1: r.b = fixed_t'($urandom_range(1, 4));
        2: r.b = -fixed_t'($urandom_range(1, 4));
        3: r.b = 32'h0001_0000;
        default: r.b = $urandom;
      endcase
      if (r.a == 32'h8000_0000 && r.b == 32'hFFFF_FFFF) r.b = 32'h0000_0002;
      req_q.push_back(r);
    end
    wait_done(target, 6000, "random");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_requester.md
DIV_REQUESTER -- requirements
Module: div_requester

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 16, meaning fractional bits of the Q(32-FRAC_BITS).FRAC_BITS signed operands and result.
REQ-002 SHALL have parameter MAX_WAIT, default 64, meaning upper bound in cycles for the divider-result wait counter width.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_a input 32, in_b input 32: request of signed fixed-point dividend a and divisor b.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1, out_q output 32, out_div_by_zero output 1: signed fixed-point quotient and divide-by-zero flag.
REQ-007 SHALL have ports m_axis_dividend_tvalid output 1, m_axis_dividend_tready input 1, m_axis_dividend_tdata output 48: the dividend channel to Divider.
REQ-008 SHALL have ports m_axis_divisor_tvalid output 1, m_axis_divisor_tready input 1, m_axis_divisor_tdata output 32: the divisor channel to Divider.
REQ-009 SHALL have ports s_axis_dout_tvalid input 1, s_axis_dout_tready output 1, s_axis_dout_tdata input 48: the quotient channel from Divider.

Function
REQ-010 SHALL implement states IDLE, SEND, WAIT, OUT.
REQ-011 SHALL assert in_ready only in IDLE; on in_valid&in_ready it SHALL register operands and enter SEND next cycle.
REQ-012 SHALL form dividend = sign-extend(a) to 48 bits, shifted left FRAC_BITS; divisor = b unchanged.
REQ-013 SHALL, in SEND, assert each channel's tvalid with stable tdata until that channel's own handshake, then deassert it; channels complete independently, in either order or in the same cycle.
REQ-014 SHALL enter WAIT in the cycle after both channels have handshaken.
REQ-015 SHALL assert s_axis_dout_tready only in WAIT; on the dout handshake it SHALL capture the quotient and enter OUT.
REQ-016 SHALL saturate the 48-bit quotient to 32 bits: above 0x7FFFFFFF gives 0x7FFFFFFF; below 0x80000000 gives 0x80000000.
REQ-017 SHALL hold out_valid, out_q and out_div_by_zero stable in OUT until out_ready, then return to IDLE; in_ready reasserts the next cycle, giving at most one request in flight.
REQ-018 SHALL ignore s_axis_dout_tvalid outside WAIT and in_valid outside IDLE.
REQ-019 SHALL give a minimum latency from input handshake to out_valid of 3 cycles plus the divider latency.

Reset
REQ-020 SHALL, on reset at any time including mid-SEND or mid-WAIT, enter IDLE.
REQ-021 SHALL, under reset, drive out_valid, out_div_by_zero, all tvalid and s_axis_dout_tready to 0, and out_q and all tdata to 0.
REQ-022 SHALL not rely on a Divider result pending across reset; the Divider SHALL be reset by the same signal.

Configuration
REQ-023 SHALL use macro DIV_ZERO_CHECK_EN to compile in the divide-by-zero check.
REQ-024 SHALL, when DIV_ZERO_CHECK_EN is defined and b==0, skip SEND/WAIT and go IDLE->OUT with out_q = 0x7FFFFFFF if a>=0 else 0x80000000, out_div_by_zero=1, and no tvalid asserted.
REQ-025 SHALL, when DIV_ZERO_CHECK_EN is undefined, send b==0 to the Divider like any value, with out_div_by_zero tied to 0.

Structure
REQ-026 SHALL place the FRAC_BITS default constant, the 32-bit fixed type and the 48-bit wide type in fixed_pkg.
REQ-027 SHALL keep saturation in one sub-module, fixed_saturate (48-bit to 32-bit signed, combinational), instantiated once.

Verification
REQ-028 SHALL cover: a=0x000A0000, b=0x00020000 -> dividend tdata 0x000A00000000, out_q 0x00050000, flag 0.
REQ-029 SHALL cover: a=0xFFFD0000, b=0x00020000 -> out_q 0xFFFE8000 (-1.5).
REQ-030 SHALL cover: a=0x7FFF0000, b=0x00000001 -> out_q 0x7FFFFFFF (saturated).
REQ-031 SHALL cover, with DIV_ZERO_CHECK_EN: a=0x00010000, b=0 -> out_q 0x7FFFFFFF, flag 1, no tvalid seen; a=0xFFFF0000, b=0 -> out_q 0x80000000.
REQ-032 SHALL cover: divisor tready held low 3 cycles after the dividend handshake -> dividend tvalid drops after 1 cycle, divisor tdata stable, WAIT entered the cycle after the divisor handshake.
REQ-033 SHALL cover: reset asserted in WAIT, then a=0x00060000, b=0x00030000 -> all outputs 0 during reset, then out_q 0x00020000.
